fifo_axis_reader: RTL and testbench
===================================

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: width of the FIFO read data and of m_axis_tdata.
REQ-002 SHALL have parameter RD_LATENCY, default 1, legal range 1..2: cycles from an accepted fifo_rd_en to valid fifo_rd_data.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of pkt_len.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port fifo_rd_en, output, 1 bit: pop request to the sync_fifo_controller read side.
REQ-007 SHALL have port fifo_rd_data, input, DATA_WIDTH bits: popped word from the FIFO.
REQ-008 SHALL have port fifo_empty_n, input, 1 bit: FIFO holds at least one word.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: stream beat valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the beat.
REQ-011 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: stream data.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: last beat of a packet.
REQ-013 SHALL have port pkt_len, input, LEN_WIDTH bits: beats per packet.
REQ-014 SHALL have port level, output, 2 bits: current skid-buffer occupancy.

Function
REQ-015 SHALL contain a skid buffer of BUF_DEPTH = RD_LATENCY+1 entries, with m_axis_tdata driven from the head register.
REQ-016 SHALL define occupancy as in-flight reads plus buffered words, never exceeding BUF_DEPTH.
REQ-017 SHALL drive fifo_rd_en = fifo_empty_n & ~reset & (occupancy < BUF_DEPTH | (occupancy == BUF_DEPTH & m_axis_tvalid & m_axis_tready)), combinationally.
REQ-018 SHALL track in-flight reads in a RD_LATENCY-deep valid shift pipe and write fifo_rd_data into the buffer tail in the cycle its pipe bit exits.
REQ-019 SHALL assert m_axis_tvalid iff the buffer count is nonzero, with tvalid and tdata held stable until a handshake (tvalid & tready).
REQ-020 SHALL perform a simultaneous push and pop in one cycle, with the count unchanged and FIFO order preserved.
REQ-021 SHALL sustain one beat per cycle with continuous tready and a non-empty FIFO after an initial latency of RD_LATENCY+1 cycles from the first fifo_rd_en.
REQ-022 SHALL never issue fifo_rd_en while fifo_empty_n=0, and SHALL never drop or duplicate a word.
REQ-023 SHALL hold the buffer on tready low; once occupancy reaches BUF_DEPTH, fifo_rd_en SHALL stay 0 until a pop.
REQ-024 SHALL drive level equal to the buffered word count, 0..BUF_DEPTH.

Reset
REQ-025 SHALL on reset clear the buffer, pipe and counters, with fifo_rd_en=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0 and level=0.
REQ-026 SHALL on reset asserted mid-operation discard in-flight reads; the FIFO controller is reset on the same reset.
REQ-027 SHALL, in the first cycle after reset deasserts, issue fifo_rd_en only if fifo_empty_n=1.

Configuration
REQ-028 SHALL, with macro FIFO_AXIS_READER_TLAST_EN defined, keep a LEN_WIDTH beat counter: effective length = pkt_len, or 1 if pkt_len=0, captured at the first-beat handshake; tlast = tvalid & (beat index == length-1); the counter resets to 0 after a tlast handshake.
REQ-029 SHALL sample pkt_len live while the beat counter is 0, so mid-packet pkt_len changes do not affect the current packet.
REQ-030 SHALL, without FIFO_AXIS_READER_TLAST_EN, tie m_axis_tlast to 0 and synthesize no counter; pkt_len SHALL be unused.

Verification
REQ-031 SHALL cover: RD_LATENCY=1, 5 words 0..4 in the FIFO, tready=1 -> fifo_rd_en on 5 consecutive cycles, tdata 0..4 on consecutive cycles, no gaps.
REQ-032 SHALL cover: tready=0 with 10 words available -> exactly 2 pops, level=2, tdata=first word; tready=1 -> remaining 8 words delivered in order.
REQ-033 SHALL cover: TLAST_EN, pkt_len=3, 7 words -> tlast on beats 2, 5; pkt_len changed to 1 during beat 6 -> tlast on beat 6 only if sampled at its start; pkt_len=0 -> tlast every beat.
REQ-034 SHALL cover: FIFO empties mid-stream -> fifo_rd_en=0, tvalid falls after the buffer drains; refill -> resumes with no lost word.
REQ-035 SHALL cover: reset asserted with 1 read in flight and 2 buffered -> all outputs 0 immediately; after release a new FIFO stream starts at its first word.
REQ-036 SHALL cover: RD_LATENCY=2, random tready at 50% -> order preserved, occupancy never exceeds 3, and fifo_rd_en never asserts while empty.

Source files
------------

// File: rtl/fifo_axis_reader.sv
// Skid-buffered reader that turns a fixed-latency FIFO read port into an AXI-Stream master.
// Define FIFO_AXIS_READER_TLAST_EN to generate m_axis_tlast from pkt_len; otherwise tlast is tied low.
module fifo_axis_reader #(
   parameter int DATA_WIDTH = 24,
   parameter int RD_LATENCY = 1,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty_n,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   output logic [1:0]            level
);

   localparam int         BUF_DEPTH = RD_LATENCY + 1;
   localparam int         CNT_W     = 2;
   localparam logic [2:0] OCC_MAX   = 3'(BUF_DEPTH);

   logic [RD_LATENCY-1:0] vld_p;
   logic [RD_LATENCY-1:0] vld_nxt;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_nxt;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W-1:0]      wr_idx;
   logic [2:0]            occ;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] skid_q   [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] skid_nxt [BUF_DEPTH];

   function automatic logic [CNT_W-1:0] count_inflight(input logic [RD_LATENCY-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   assign inflight      = count_inflight(vld_p);
   assign occ           = {1'b0, inflight} + {1'b0, count_q};
   assign m_axis_tvalid = (count_q != '0);
   assign m_axis_tdata  = skid_q[0];
   assign level         = count_q;
   assign pop           = m_axis_tvalid & m_axis_tready;
   assign push          = vld_p[RD_LATENCY-1];

   // Read-issue stage: a full buffer may still pop when the head is leaving this cycle
   assign fifo_rd_en = fifo_empty_n & ~reset &
                       ((occ < OCC_MAX) | ((occ == OCC_MAX) & pop));

   always_comb begin
      vld_nxt    = vld_p << 1;
      vld_nxt[0] = fifo_rd_en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p <= '0;
      end else begin
         vld_p <= vld_nxt;
      end
   end

   // Return stage: a word leaving the pipe lands behind the last valid entry
   assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
   assign wr_idx    = pop ? (count_q - CNT_W'(1)) : count_q;

   always_comb begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
         skid_nxt[i] = skid_q[i];
      end
      if (pop) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) begin
            skid_nxt[i] = skid_q[i+1];
         end
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (push && (wr_idx == CNT_W'(i))) begin
            skid_nxt[i] = fifo_rd_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_nxt;
      end
   end

   // The head register is cleared as well so tdata reads zero out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            skid_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            skid_q[i] <= skid_nxt[i];
         end
      end
   end

`ifdef FIFO_AXIS_READER_TLAST_EN
   logic [LEN_WIDTH-1:0] beat_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] len_eff;

   // pkt_len is only looked at while the first beat of a packet is on the bus
   always_comb begin
      if (beat_q == '0) begin
         len_eff = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
      end else begin
         len_eff = len_q;
      end
   end

   assign m_axis_tlast = m_axis_tvalid & (beat_q == (len_eff - LEN_WIDTH'(1)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_q <= '0;
         len_q  <= '0;
      end else if (pop) begin
         if (beat_q == '0) begin
            len_q <= len_eff;
         end
         if (m_axis_tlast) begin
            beat_q <= '0;
         end else begin
            beat_q <= beat_q + LEN_WIDTH'(1);
         end
      end
   end
`else
   logic unused_pkt_len;

   assign unused_pkt_len = ^pkt_len;
   assign m_axis_tlast   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader: one instance at RD_LATENCY=1 and one at RD_LATENCY=2,
// each fed by a small behavioural FIFO whose read data appears RD_LATENCY cycles after a pop.
module tb_fifo_axis_reader;

`ifdef FIFO_AXIS_READER_TLAST_EN
   localparam bit TLAST_ON = 1'b1;
`else
   localparam bit TLAST_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] pkt_len = '0;

   logic        rd_en_a, empty_n_a, tvalid_a, tready_a, tlast_a;
   logic [23:0] rdat_a, tdata_a;
   logic [1:0]  level_a;
   logic        rd_en_b, empty_n_b, tvalid_b, tready_b, tlast_b;
   logic [23:0] rdat_b1, rdat_b2, tdata_b;
   logic [1:0]  level_b;

   logic [23:0] mem_a [128];
   logic [23:0] mem_b [128];
   int          wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
   logic [23:0] rx_a [$];
   logic        rxl_a [$];
   logic [23:0] rx_b [$];
   int          viol_empty = 0;
   int          max_occ_b = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   fifo_axis_reader #(.DATA_WIDTH(24), .RD_LATENCY(1), .LEN_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .fifo_rd_en(rd_en_a), .fifo_rd_data(rdat_a),
      .fifo_empty_n(empty_n_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
      .m_axis_tdata(tdata_a), .m_axis_tlast(tlast_a), .pkt_len(pkt_len), .level(level_a));

   fifo_axis_reader #(.DATA_WIDTH(24), .RD_LATENCY(2), .LEN_WIDTH(16)) dut_b (
      .clk(clk), .reset(reset), .fifo_rd_en(rd_en_b), .fifo_rd_data(rdat_b2),
      .fifo_empty_n(empty_n_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
      .m_axis_tdata(tdata_b), .m_axis_tlast(tlast_b), .pkt_len(pkt_len), .level(level_b));

   // Behavioural FIFOs: pointers reset with the reader, read data registers deliberately do not
   assign empty_n_a = (rd_a < wr_a);
   assign empty_n_b = (rd_b < wr_b);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_a <= 0;
         rd_b <= 0;
      end else begin
         if (rd_en_a && empty_n_a) rd_a <= rd_a + 1;
         if (rd_en_b && empty_n_b) rd_b <= rd_b + 1;
      end
   end

   always @(posedge clk) begin
      if (rd_en_a && empty_n_a) rdat_a <= mem_a[rd_a[6:0]];
      if (rd_en_b && empty_n_b) rdat_b1 <= mem_b[rd_b[6:0]];
      rdat_b2 <= rdat_b1;
   end

   // Handshakes are observed mid-cycle, where inputs and outputs are settled.
   always @(negedge clk) begin
      int occ_b;
      if (rd_en_a && !empty_n_a) viol_empty++;
      if (rd_en_b && !empty_n_b) viol_empty++;
      if (!reset) begin
         if (tvalid_a && tready_a) begin
            rx_a.push_back(tdata_a);
            rxl_a.push_back(tlast_a);
         end
         if (tvalid_b && tready_b) rx_b.push_back(tdata_b);
         occ_b = rd_b - rx_b.size();
         if (occ_b > max_occ_b) max_occ_b = occ_b;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rx_at(input int src, input int k);
      if (src == 0) return (k < rx_a.size()) ? 32'(rx_a[k]) : 32'hFFFF_FFFF;
      return (k < rx_b.size()) ? 32'(rx_b[k]) : 32'hFFFF_FFFF;
   endfunction

   task automatic do_reset(input int na, input int base_a, input int nb, input int base_b);
      reset = 1'b1;
      tready_a = 1'b0;
      tready_b = 1'b0;
      wr_a = 0;
      wr_b = 0;
      rx_a.delete();
      rxl_a.delete();
      rx_b.delete();
      @(posedge clk);
      #1;
      for (int k = 0; k < na; k++) mem_a[k] = 24'(base_a + k);
      for (int k = 0; k < nb; k++) mem_b[k] = 24'(base_b + k);
      wr_a = na;
      wr_b = nb;
      #1;
      chk("rst_rd_en_a", 32'(rd_en_a), 0);
      chk("rst_tvalid_a", 32'(tvalid_a), 0);
      chk("rst_tdata_a", 32'(tdata_a), 0);
      chk("rst_tlast_a", 32'(tlast_a), 0);
      chk("rst_level_a", 32'(level_a), 0);
      chk("rst_rd_en_b", 32'(rd_en_b), 0);
      chk("rst_level_b", 32'(level_b), 0);
      reset = 1'b0;
      max_occ_b = 0;
      #1;
      chk("post_rst_rd_en_a", 32'(rd_en_a), 32'(na > 0));
      chk("post_rst_rd_en_b", 32'(rd_en_b), 32'(nb > 0));
   endtask

   typedef struct packed {
      int load_n;
      int base;
      bit rdy;
      bit rd;
      bit tv;
      int td;
      int lv;
   } vec_t;

   function automatic vec_t mk(input int load_n, input int base, input bit rdy, input bit rd,
                               input bit tv, input int td, input int lv);
      vec_t v;
      v.load_n = load_n; v.base = base; v.rdy = rdy; v.rd = rd;
      v.tv = tv; v.td = td; v.lv = lv;
      return v;
   endfunction

   vec_t tbl [24];

   initial begin
      logic [6:0] exp_last;

      // Streaming 0..4 with tready high, then tready low against 10 queued words.
      tbl[0]  = mk(5, 0, 1, 1, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 1, 1, 0, 1);
      tbl[3]  = mk(0, 0, 1, 1, 1, 1, 1);
      tbl[4]  = mk(0, 0, 1, 1, 1, 2, 1);
      tbl[5]  = mk(0, 0, 1, 0, 1, 3, 1);
      tbl[6]  = mk(0, 0, 1, 0, 1, 4, 1);
      tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0);
      tbl[8]  = mk(10, 100, 0, 1, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 1, 100, 1);
      tbl[11] = mk(0, 0, 0, 0, 1, 100, 2);
      tbl[12] = mk(0, 0, 0, 0, 1, 100, 2);
      tbl[13] = mk(0, 0, 1, 1, 1, 100, 2);
      for (int k = 0; k < 7; k++) tbl[14+k] = mk(0, 0, 1, 1, 1, 101 + k, 1);
      tbl[21] = mk(0, 0, 1, 0, 1, 108, 1);
      tbl[22] = mk(0, 0, 1, 0, 1, 109, 1);
      tbl[23] = mk(0, 0, 1, 0, 0, 0, 0);

      tready_a = 1'b0;
      tready_b = 1'b0;
      pkt_len  = '0;

      for (int i = 0; i < 24; i++) begin
         if (tbl[i].load_n != 0) do_reset(tbl[i].load_n, tbl[i].base, 0, 0);
         tready_a = tbl[i].rdy;
         #1;
         chk($sformatf("v%0d_rd_en", i), 32'(rd_en_a), 32'(tbl[i].rd));
         chk($sformatf("v%0d_tvalid", i), 32'(tvalid_a), 32'(tbl[i].tv));
         chk($sformatf("v%0d_level", i), 32'(level_a), 32'(tbl[i].lv));
         chk($sformatf("v%0d_tlast", i), 32'(tlast_a), 32'(TLAST_ON & tbl[i].tv));
         if (tbl[i].tv) chk($sformatf("v%0d_tdata", i), 32'(tdata_a), 32'(tbl[i].td));
         step(1);
      end

      // FIFO runs dry mid-stream, then refills.
      do_reset(3, 200, 0, 0);
      tready_a = 1'b1;
      step(3);
      chk("drain_rd_en", 32'(rd_en_a), 0);
      chk("drain_tvalid_still", 32'(tvalid_a), 1);
      chk("drain_tdata", 32'(tdata_a), 201);
      step(5);
      chk("drained_tvalid", 32'(tvalid_a), 0);
      chk("drained_level", 32'(level_a), 0);
      chk("drained_count", 32'(rx_a.size()), 3);
      for (int k = 3; k < 6; k++) mem_a[k] = 24'(200 + k);
      wr_a = 6;
      step(8);
      chk("refill_count", 32'(rx_a.size()), 6);
      for (int k = 0; k < 6; k++) chk($sformatf("refill_word%0d", k), rx_at(0, k), 32'(200 + k));

      // Reset with one read in flight and two words buffered (RD_LATENCY=2).
      do_reset(0, 0, 8, 400);
      step(4);
      chk("midrst_level_before", 32'(level_b), 2);
      chk("midrst_tdata_before", 32'(tdata_b), 400);
      chk("midrst_rd_en_full", 32'(rd_en_b), 0);
      reset = 1'b1;
      #1;
      chk("midrst_rd_en", 32'(rd_en_b), 0);
      chk("midrst_tvalid", 32'(tvalid_b), 0);
      chk("midrst_tdata", 32'(tdata_b), 0);
      chk("midrst_tlast", 32'(tlast_b), 0);
      chk("midrst_level", 32'(level_b), 0);
      do_reset(0, 0, 6, 500);
      tready_b = 1'b1;
      step(20);
      chk("newstream_count", 32'(rx_b.size()), 6);
      for (int k = 0; k < 6; k++) chk($sformatf("newstream_word%0d", k), rx_at(1, k), 32'(500 + k));

      // Full stall at RD_LATENCY=2, then random backpressure.
      do_reset(0, 0, 60, 600);
      step(6);
      chk("stall_level", 32'(level_b), 3);
      chk("stall_rd_en", 32'(rd_en_b), 0);
      chk("stall_tdata", 32'(tdata_b), 600);
      for (int c = 0; c < 600 && rx_b.size() < 60; c++) begin
         tready_b = 1'($urandom_range(0, 1));
         step(1);
      end
      tready_b = 1'b1;
      chk("rand_count", 32'(rx_b.size()), 60);
      for (int k = 0; k < 60; k++) chk($sformatf("rand_word%0d", k), rx_at(1, k), 32'(600 + k));
      n_tests++;
      if (max_occ_b > 3) begin
         n_fail++;
         $display("FAIL rand_occupancy: got %0d expected at most 3", max_occ_b);
      end

`ifdef FIFO_AXIS_READER_TLAST_EN
      // Packets of 3; a mid-packet pkt_len change is ignored, a first-beat change is honoured.
      pkt_len = 16'd3;
      do_reset(7, 700, 0, 0);
      tready_a = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (rx_a.size() == 4) pkt_len = 16'd2;
         if (rx_a.size() == 6) pkt_len = 16'd1;
         step(1);
      end
      exp_last = 7'b1100100;
      chk("tlast_count", 32'(rx_a.size()), 7);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("tlast_beat%0d", k), (k < rxl_a.size()) ? 32'(rxl_a[k]) : 32'hFFFF_FFFF,
             32'(exp_last[k]));
         chk($sformatf("tlast_word%0d", k), rx_at(0, k), 32'(700 + k));
      end
      pkt_len = '0;
      for (int k = 7; k < 10; k++) mem_a[k] = 24'(700 + k);
      wr_a = 10;
      step(8);
      chk("len0_count", 32'(rx_a.size()), 10);
      for (int k = 7; k < 10; k++) begin
         chk($sformatf("len0_tlast%0d", k), (k < rxl_a.size()) ? 32'(rxl_a[k]) : 32'hFFFF_FFFF, 1);
      end
`endif

      chk("rd_en_while_empty", 32'(viol_empty), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
